ex_mem_redirect: RTL and testbench
==================================

Name: ex_mem_redirect

Overview:
- EX→MEM control-flow pipeline register; produces the `ex_mem_*` redirect bundle that the PC update block consumes.
- Captures jump/branch resolution from the EX stage and holds it one stage.
- Generates the one-shot redirect/flush for the IF/ID and ID/EX registers.
- Squashes the wrong-path instruction in EX so a redirect is taken exactly once.

Parameters:
ADDR_LEN, 32, address/PC width in bits; every address port uses this width.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; one clock, asynchronous, active-high
hold  in  1  pipeline hold (stall); freezes this register, suppresses redirect
id_ex_valid  in  1  instruction in EX is real (not a bubble)
ex_jump_flag  in  1  EX instruction is an unconditional jump
ex_jump_target  in  ADDR_LEN  jump destination
ex_branch_flag  in  1  EX instruction is a conditional branch
ex_zero  in  1  ALU zero, i.e. branch condition true
ex_branch_target  in  ADDR_LEN  branch destination
ex_pc_plus_4  in  ADDR_LEN  EX instruction PC+4
ex_mem_valid  out  1  registered valid
ex_mem_jump_flag  out  1  registered jump flag
ex_mem_jump_target  out  ADDR_LEN  registered jump target
ex_mem_branch_flag  out  1  registered branch flag
ex_mem_zero  out  1  registered zero
ex_mem_branch_target  out  ADDR_LEN  registered branch target
ex_mem_pc_plus_4  out  ADDR_LEN  registered PC+4
redirect  out  1  combinational; PC takes non-sequential target this edge
redirect_target  out  ADDR_LEN  combinational; destination when redirect=1
flush_if_id  out  1  combinational; clear IF/ID on this edge
flush_id_ex  out  1  combinational; clear ID/EX on this edge

Behaviour:
- Reset (async, rst=1): all `ex_mem_*` registers go to 0. `redirect`, `flush_if_id` and `flush_id_ex` are therefore 0. `redirect_target` is 0.
- Redirect condition: `redirect = ex_mem_valid & ~hold & (ex_mem_jump_flag | (ex_mem_branch_flag & ex_mem_zero))`.
- Target priority: if jump flag is set, `redirect_target = ex_mem_jump_target`; otherwise `ex_mem_branch_target`. Jump wins when both flags are set, matching PC priority.
- Not-taken branch (branch_flag=1, zero=0): `redirect=0`; PC continues at `ex_mem_pc_plus_4`.
- Flushes: `flush_if_id = flush_id_ex = redirect`.
- Register update on posedge with hold=0:
  - `ex_mem_valid <= id_ex_valid & ~redirect`, which squashes the wrong-path EX instruction.
  - Data/flag fields capture the EX inputs unconditionally; they are don't-care when valid=0.
- Register update on posedge with hold=1: all registers retain their values; redirect and flushes are forced to 0.
- Latency: EX inputs appear on `ex_mem_*` 1 cycle later. Redirect is visible the same cycle the instruction sits in EX/MEM.
- Three wrong-path instructions are killed per redirect: IF (via IF/ID flush), ID (via ID/EX flush) and EX (via valid squash).
- Hold with a pending redirect: the redirect stays latent and fires exactly once, on the first cycle with hold=0.
- Back-to-back control flow: an instruction squashed behind a redirect cannot redirect, because valid=0. The next redirect comes only from a correct-path instruction.
- A bubble (`id_ex_valid=0`) with flags set never redirects.
- Reset asserted mid-redirect: outputs clear immediately (asynchronously). No redirect is issued after reset releases.

Optional Feature:
REDIRECT_STATS_EN:
- When defined, adds outputs `taken_cnt` (32) and `branch_cnt` (32), both reset to 0 and wrapping modulo 2^32.
- `branch_cnt` increments on each posedge where `ex_mem_valid & ~hold & ex_mem_branch_flag`.
- `taken_cnt` increments on each posedge where `redirect=1`.
- The counters are counted once per instruction, even across multi-cycle holds.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset → all `ex_mem_*` = 0, `redirect=0`, `redirect_target=0`, with no clock edge needed.
- Valid jump in EX, target 0x40 → next cycle: `ex_mem_jump_flag=1`, `redirect=1`, `redirect_target=0x40`, both flushes 1. Following cycle: `ex_mem_valid=0` even though `id_ex_valid=1`.
- Valid branch, zero=0, pc_plus_4 0x1C → `ex_mem_branch_flag=1`, `redirect=0`, `ex_mem_pc_plus_4=0x1C`. With zero=1 and target 0x08 → `redirect=1`, `redirect_target=0x08`.
- Jump (0x100) and branch (0x200, zero=1) flags both set → `redirect_target=0x100`.
- Taken branch in EX/MEM with hold=1 for 3 cycles → redirect=0 and registers unchanged for 3 cycles. `redirect=1` for exactly one cycle after hold drops. With REDIRECT_STATS_EN: `taken_cnt` 0→1 and `branch_cnt` 0→1.
- rst pulsed between edges while `redirect=1` → `redirect` and `ex_mem_valid` drop immediately and stay 0 after release until a new valid jump arrives.

Source files
------------

// File: rtl/ex_mem_redirect.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_redirect
//  Description : EX->MEM control-flow pipeline register. It generates the
//                one-shot redirect and the IF/ID and ID/EX flushes, and it
//                squashes the wrong-path instruction in EX.
//                Optional macro REDIRECT_STATS_EN adds taken/branch counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_redirect #(
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic                id_ex_valid,
    input  logic                ex_jump_flag,
    input  logic [ADDR_LEN-1:0] ex_jump_target,
    input  logic                ex_branch_flag,
    input  logic                ex_zero,
    input  logic [ADDR_LEN-1:0] ex_branch_target,
    input  logic [ADDR_LEN-1:0] ex_pc_plus_4,
    output logic                ex_mem_valid,
    output logic                ex_mem_jump_flag,
    output logic [ADDR_LEN-1:0] ex_mem_jump_target,
    output logic                ex_mem_branch_flag,
    output logic                ex_mem_zero,
    output logic [ADDR_LEN-1:0] ex_mem_branch_target,
    output logic [ADDR_LEN-1:0] ex_mem_pc_plus_4,
    output logic                redirect,
    output logic [ADDR_LEN-1:0] redirect_target,
    output logic                flush_if_id,
    output logic                flush_id_ex
`ifdef REDIRECT_STATS_EN
    ,
    output logic [31:0]         taken_cnt,
    output logic [31:0]         branch_cnt
`endif
);

    logic                r_valid_q,         w_valid_d;
    logic                r_jump_flag_q,     w_jump_flag_d;
    logic [ADDR_LEN-1:0] r_jump_target_q,   w_jump_target_d;
    logic                r_branch_flag_q,   w_branch_flag_d;
    logic                r_zero_q,          w_zero_d;
    logic [ADDR_LEN-1:0] r_branch_target_q, w_branch_target_d;
    logic [ADDR_LEN-1:0] r_pc_plus_4_q,     w_pc_plus_4_d;
    logic                w_redirect;
    logic [ADDR_LEN-1:0] w_redirect_target;

    always_comb begin
        // Hold keeps a pending redirect latent so it fires exactly once later.
        w_redirect        = r_valid_q & ~hold &
                            (r_jump_flag_q | (r_branch_flag_q & r_zero_q));
        w_redirect_target = r_jump_flag_q ? r_jump_target_q : r_branch_target_q;

        w_valid_d         = r_valid_q;
        w_jump_flag_d     = r_jump_flag_q;
        w_jump_target_d   = r_jump_target_q;
        w_branch_flag_d   = r_branch_flag_q;
        w_zero_d          = r_zero_q;
        w_branch_target_d = r_branch_target_q;
        w_pc_plus_4_d     = r_pc_plus_4_q;
        if (!hold) begin
            // The instruction in EX is wrong-path whenever we redirect now.
            w_valid_d         = id_ex_valid & ~w_redirect;
            w_jump_flag_d     = ex_jump_flag;
            w_jump_target_d   = ex_jump_target;
            w_branch_flag_d   = ex_branch_flag;
            w_zero_d          = ex_zero;
            w_branch_target_d = ex_branch_target;
            w_pc_plus_4_d     = ex_pc_plus_4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_q         <= 1'b0;
            r_jump_flag_q     <= 1'b0;
            r_jump_target_q   <= '0;
            r_branch_flag_q   <= 1'b0;
            r_zero_q          <= 1'b0;
            r_branch_target_q <= '0;
            r_pc_plus_4_q     <= '0;
        end else begin
            r_valid_q         <= w_valid_d;
            r_jump_flag_q     <= w_jump_flag_d;
            r_jump_target_q   <= w_jump_target_d;
            r_branch_flag_q   <= w_branch_flag_d;
            r_zero_q          <= w_zero_d;
            r_branch_target_q <= w_branch_target_d;
            r_pc_plus_4_q     <= w_pc_plus_4_d;
        end
    end

    assign ex_mem_valid         = r_valid_q;
    assign ex_mem_jump_flag     = r_jump_flag_q;
    assign ex_mem_jump_target   = r_jump_target_q;
    assign ex_mem_branch_flag   = r_branch_flag_q;
    assign ex_mem_zero          = r_zero_q;
    assign ex_mem_branch_target = r_branch_target_q;
    assign ex_mem_pc_plus_4     = r_pc_plus_4_q;
    assign redirect             = w_redirect;
    assign redirect_target      = w_redirect_target;
    assign flush_if_id          = w_redirect;
    assign flush_id_ex          = w_redirect;

`ifdef REDIRECT_STATS_EN
    logic [31:0] r_taken_cnt_q,  w_taken_cnt_d;
    logic [31:0] r_branch_cnt_q, w_branch_cnt_d;

    // Gating on ~hold makes each instruction count once across a long stall.
    always_comb begin
        w_taken_cnt_d  = r_taken_cnt_q;
        w_branch_cnt_d = r_branch_cnt_q;
        if (w_redirect) begin
            w_taken_cnt_d = r_taken_cnt_q + 32'd1;
        end
        if (r_valid_q && !hold && r_branch_flag_q) begin
            w_branch_cnt_d = r_branch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_taken_cnt_q  <= 32'd0;
            r_branch_cnt_q <= 32'd0;
        end else begin
            r_taken_cnt_q  <= w_taken_cnt_d;
            r_branch_cnt_q <= w_branch_cnt_d;
        end
    end

    assign taken_cnt  = r_taken_cnt_q;
    assign branch_cnt = r_branch_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_redirect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_redirect
//  Description : Scoreboard bench for ex_mem_redirect with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_redirect;

    logic        clk = 1'b1;
    logic        rst = 1'b0;
    logic        hold = 1'b0;
    logic        id_ex_valid = 1'b0;
    logic        ex_jump_flag = 1'b0;
    logic [31:0] ex_jump_target = '0;
    logic        ex_branch_flag = 1'b0;
    logic        ex_zero = 1'b0;
    logic [31:0] ex_branch_target = '0;
    logic [31:0] ex_pc_plus_4 = '0;
    logic        ex_mem_valid, ex_mem_jump_flag, ex_mem_branch_flag, ex_mem_zero;
    logic [31:0] ex_mem_jump_target, ex_mem_branch_target, ex_mem_pc_plus_4;
    logic        redirect, flush_if_id, flush_id_ex;
    logic [31:0] redirect_target;
`ifdef REDIRECT_STATS_EN
    logic [31:0] taken_cnt, branch_cnt;
    logic [31:0] r_taken_base, r_branch_base;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        v;
        logic        jf;
        logic [31:0] jt;
        logic        bf;
        logic        z;
        logic [31:0] bt;
        logic [31:0] pc4;
        logic        red;
        logic [31:0] rt;
        logic        ct;   // compare redirect_target
    } exp_t;

    exp_t exp_q[$];

    ex_mem_redirect #(.ADDR_LEN(32)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .hold                 (hold),
        .id_ex_valid          (id_ex_valid),
        .ex_jump_flag         (ex_jump_flag),
        .ex_jump_target       (ex_jump_target),
        .ex_branch_flag       (ex_branch_flag),
        .ex_zero              (ex_zero),
        .ex_branch_target     (ex_branch_target),
        .ex_pc_plus_4         (ex_pc_plus_4),
        .ex_mem_valid         (ex_mem_valid),
        .ex_mem_jump_flag     (ex_mem_jump_flag),
        .ex_mem_jump_target   (ex_mem_jump_target),
        .ex_mem_branch_flag   (ex_mem_branch_flag),
        .ex_mem_zero          (ex_mem_zero),
        .ex_mem_branch_target (ex_mem_branch_target),
        .ex_mem_pc_plus_4     (ex_mem_pc_plus_4),
        .redirect             (redirect),
        .redirect_target      (redirect_target),
        .flush_if_id          (flush_if_id),
        .flush_id_ex          (flush_id_ex)
`ifdef REDIRECT_STATS_EN
        ,
        .taken_cnt            (taken_cnt),
        .branch_cnt           (branch_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic v, input logic jf, input logic [31:0] jt,
                                input logic bf, input logic z, input logic [31:0] bt,
                                input logic [31:0] pc4, input logic red,
                                input logic [31:0] rt, input logic ct);
        exp_t e;
        e.v = v; e.jf = jf; e.jt = jt; e.bf = bf; e.z = z; e.bt = bt;
        e.pc4 = pc4; e.red = red; e.rt = rt; e.ct = ct;
        return e;
    endfunction

    // One EX-stage cycle: drive inputs after the edge and queue what the
    // EX/MEM outputs must show during that same cycle.
    task automatic step(input logic v, input logic jf, input logic [31:0] jt,
                        input logic bf, input logic z, input logic [31:0] bt,
                        input logic [31:0] pc4, input logic h, input exp_t e);
        @(posedge clk);
        #1;
        id_ex_valid = v; ex_jump_flag = jf; ex_jump_target = jt;
        ex_branch_flag = bf; ex_zero = z; ex_branch_target = bt;
        ex_pc_plus_4 = pc4; hold = h;
        exp_q.push_back(e);
    endtask

    // Monitor: samples mid-cycle and after an asynchronous reset pulse.
    initial begin : p_monitor
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk or negedge rst);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ok = (ex_mem_valid === e.v) && (ex_mem_jump_flag === e.jf) &&
                     (ex_mem_jump_target === e.jt) && (ex_mem_branch_flag === e.bf) &&
                     (ex_mem_zero === e.z) && (ex_mem_branch_target === e.bt) &&
                     (ex_mem_pc_plus_4 === e.pc4) && (redirect === e.red) &&
                     (flush_if_id === e.red) && (flush_id_ex === e.red) &&
                     (!e.ct || (redirect_target === e.rt));
                n_tests++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL cycle_check t=%0t got v=%b jf=%b jt=%h bf=%b z=%b bt=%h pc4=%h red=%b fl=%b%b rt=%h | exp v=%b jf=%b jt=%h bf=%b z=%b bt=%h pc4=%h red=%b rt=%h(chk=%b)",
                             $time, ex_mem_valid, ex_mem_jump_flag, ex_mem_jump_target,
                             ex_mem_branch_flag, ex_mem_zero, ex_mem_branch_target,
                             ex_mem_pc_plus_4, redirect, flush_if_id, flush_id_ex,
                             redirect_target, e.v, e.jf, e.jt, e.bf, e.z, e.bt, e.pc4,
                             e.red, e.rt, e.ct);
                end
            end
        end
    end

    initial begin : p_stim
        // Reset with no clock edge: first posedge is at t=10, checked at t=5.
        #1;
        rst = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Jump to 0x40, then a squashed wrong-path instruction.
        step(1, 1, 32'h40,  0, 0, 0,       32'h04, 0, mk(0, 0, 0,      0, 0, 0,      32'h00, 0, 0,      0));
        step(1, 0, 0,       0, 0, 0,       32'h10, 0, mk(1, 1, 32'h40, 0, 0, 0,      32'h04, 1, 32'h40, 1));
        // Not-taken branch, then taken branch to 0x08.
        step(1, 0, 0,       1, 0, 32'h30,  32'h1C, 0, mk(0, 0, 0,      0, 0, 0,      32'h10, 0, 0,      0));
        step(1, 0, 0,       1, 1, 32'h08,  32'h20, 0, mk(1, 0, 0,      1, 0, 32'h30, 32'h1C, 0, 0,      0));
        step(1, 0, 0,       0, 0, 0,       32'h24, 0, mk(1, 0, 0,      1, 1, 32'h08, 32'h20, 1, 32'h08, 1));
        // Jump and taken branch together: jump target wins.
        step(1, 1, 32'h100, 1, 1, 32'h200, 32'h30, 0, mk(0, 0, 0,      0, 0, 0,      32'h24, 0, 0,      0));
        step(1, 0, 0,       0, 0, 0,       32'h34, 0, mk(1, 1, 32'h100,1, 1, 32'h200,32'h30, 1, 32'h100,1));
        // Taken branch held for three cycles, fires once when hold drops.
        step(1, 0, 0,       1, 1, 32'h80,  32'h50, 0, mk(0, 0, 0,      0, 0, 0,      32'h34, 0, 0,      0));
        step(1, 0, 0,       0, 0, 0,       32'h60, 1, mk(1, 0, 0,      1, 1, 32'h80, 32'h50, 0, 0,      0));
`ifdef REDIRECT_STATS_EN
        r_taken_base  = taken_cnt;
        r_branch_base = branch_cnt;
`endif
        step(1, 1, 32'h999, 0, 0, 0,       32'h90, 1, mk(1, 0, 0,      1, 1, 32'h80, 32'h50, 0, 0,      0));
        step(1, 1, 32'h999, 0, 0, 0,       32'h90, 1, mk(1, 0, 0,      1, 1, 32'h80, 32'h50, 0, 0,      0));
        step(1, 0, 0,       0, 0, 0,       32'h64, 0, mk(1, 0, 0,      1, 1, 32'h80, 32'h50, 1, 32'h80, 1));
        // Bubble carrying a jump flag must never redirect.
        step(0, 1, 32'h44,  0, 0, 0,       32'h68, 0, mk(0, 0, 0,      0, 0, 0,      32'h64, 0, 0,      0));
`ifdef REDIRECT_STATS_EN
        n_tests++;
        if (taken_cnt !== r_taken_base + 32'd1 || branch_cnt !== r_branch_base + 32'd1) begin
            n_fail++;
            $display("FAIL stats_hold got taken=%0d branch=%0d exp taken=%0d branch=%0d",
                     taken_cnt, branch_cnt, r_taken_base + 32'd1, r_branch_base + 32'd1);
        end
`endif
        step(1, 1, 32'h200, 0, 0, 0,       32'h70, 0, mk(0, 1, 32'h44, 0, 0, 0,      32'h68, 0, 0,      0));
        step(0, 0, 0,       0, 0, 0,       32'h74, 0, mk(1, 1, 32'h200,0, 0, 0,      32'h70, 1, 32'h200,1));
        // Asynchronous reset pulse between edges while redirect is active.
        @(negedge clk);
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step(0, 0, 0,       0, 0, 0,       32'h00, 0, mk(0, 0, 0,      0, 0, 0,      32'h74, 0, 0,      0));
        step(1, 1, 32'h300, 0, 0, 0,       32'h78, 0, mk(0, 0, 0,      0, 0, 0,      32'h00, 0, 0,      0));
        step(0, 0, 0,       0, 0, 0,       32'h00, 0, mk(1, 1, 32'h300,0, 0, 0,      32'h78, 1, 32'h300,1));
        step(0, 0, 0,       0, 0, 0,       32'h00, 0, mk(0, 0, 0,      0, 0, 0,      32'h00, 0, 0,      0));

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending entries, exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
